des_core: RTL and testbench

//  Fully pipelined DES (FIPS 46-3) block cipher: one 64-bit block per clock, encrypt or decrypt.
//  Key and mode travel with each block, so every cycle may carry a different key and direction.

---
 rtl/des_if.sv | 14 +
 rtl/des_core.sv | 160 ++++++++++++++++
 tb/tb_des_core.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_if.sv
// Block-in / block-out bus for des_core. Valid-only: no backpressure on either side.
interface des_if;
  // req_valid qualifies req_mode/req_key/req_data in the same cycle; rsp_valid likewise
  // qualifies rsp_data. There is no ready: every valid beat is taken and every result must be consumed.
  logic        req_valid;
  logic        req_mode;
  logic [0:63] req_key;
  logic [0:63] req_data;
  logic        rsp_valid;
  logic [0:63] rsp_data;

  modport master (output req_valid, req_mode, req_key, req_data, input rsp_valid, rsp_data);
  modport slave  (input req_valid, req_mode, req_key, req_data, output rsp_valid, rsp_data);
endinterface

// File: rtl/des_core.sv
// Fully pipelined DES encrypt/decrypt, one block per clock; key and mode ride with each block.
// DES_OUTREG_EN registers the FP result (latency 17); undefined gives a combinational FP (latency 16).
module des_core (
  input logic clk,
  input logic reset,
  des_if.slave bus
);
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // Decrypt rotates right; its first step is 0 because C0/D0 already yields K16.
  localparam int LS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int RS [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [0:63] ip_fn(input logic [0:63] x);
    for (int i = 0; i < 64; i++) ip_fn[i] = x[IP_T[i]-1];
  endfunction

  function automatic logic [0:63] fp_fn(input logic [0:63] x);
    for (int i = 0; i < 64; i++) fp_fn[i] = x[FP_T[i]-1];
  endfunction

  function automatic logic [0:55] pc1_fn(input logic [0:63] x);
    for (int i = 0; i < 56; i++) pc1_fn[i] = x[PC1_T[i]-1];
  endfunction

  function automatic logic [0:47] pc2_fn(input logic [0:55] x);
    for (int i = 0; i < 48; i++) pc2_fn[i] = x[PC2_T[i]-1];
  endfunction

  // Shifting toward index 0 is a left rotation in DES bit order.
  function automatic logic [0:27] rotl(input logic [0:27] x, input int n);
    rotl = (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] x, input int n);
    rotr = (x >> n) | (x << (28 - n));
  endfunction

  function automatic logic [0:31] f_fn(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:5]  six;
    logic [0:31] s;
    for (int i = 0; i < 48; i++) x[i] = r[E_T[i]-1];
    x = x ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[b*6 +: 6];
      s[b*4 +: 4] = SBOX[b][{six[0], six[5], six[1:4]}];
    end
    for (int i = 0; i < 32; i++) f_fn[i] = s[P_T[i]-1];
  endfunction

  // Stage 0 holds IP/PC1 of the input; stage n holds the state after round n.
  logic [0:16] valid_q;
  logic [0:16] mode_q;
  logic [0:31] l_q [0:16];
  logic [0:31] r_q [0:16];
  logic [0:27] c_q [0:16];
  logic [0:27] d_q [0:16];
  logic [0:27] c_r [1:16];
  logic [0:27] d_r [1:16];
  logic [0:31] f_r [1:16];
  logic [0:63] fp_res;

  always_comb begin
    for (int n = 1; n <= 16; n++) begin
      if (mode_q[n-1]) begin
        c_r[n] = rotr(c_q[n-1], RS[n-1]);
        d_r[n] = rotr(d_q[n-1], RS[n-1]);
      end else begin
        c_r[n] = rotl(c_q[n-1], LS[n-1]);
        d_r[n] = rotl(d_q[n-1], LS[n-1]);
      end
      f_r[n] = l_q[n-1] ^ f_fn(r_q[n-1], pc2_fn({c_r[n], d_r[n]}));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      mode_q  <= '0;
      for (int n = 0; n <= 16; n++) begin
        l_q[n] <= '0;
        r_q[n] <= '0;
        c_q[n] <= '0;
        d_q[n] <= '0;
      end
    end else begin
      valid_q[0] <= bus.req_valid;
      mode_q[0]  <= bus.req_mode;
      {l_q[0], r_q[0]} <= ip_fn(bus.req_data);
      {c_q[0], d_q[0]} <= pc1_fn(bus.req_key);
      for (int n = 1; n <= 16; n++) begin
        valid_q[n] <= valid_q[n-1];
        mode_q[n]  <= mode_q[n-1];
        c_q[n]     <= c_r[n];
        d_q[n]     <= d_r[n];
        l_q[n]     <= r_q[n-1];
        r_q[n]     <= f_r[n];
      end
    end
  end

  // Final swap folded into the FP operand: R16 goes on the left.
  assign fp_res = fp_fn({r_q[16], l_q[16]});

`ifdef DES_OUTREG_EN
  logic [0:63] out_data_q;
  logic        out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= fp_res;
      out_valid_q <= valid_q[16];
    end
  end

  assign bus.rsp_data  = out_data_q;
  assign bus.rsp_valid = out_valid_q;
`else
  assign bus.rsp_data  = fp_res;
  assign bus.rsp_valid = valid_q[16];
`endif
endmodule

// File: tb/tb_des_core.sv
// Scoreboard bench for des_core: known-answer vectors, NIST-style streams, random mixed-mode traffic, mid-stream reset.
module tb_des_core;
`ifdef DES_OUTREG_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];
  int          exp_t[$];

  des_if bus();
  des_core dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference tables, entries are 1-based bit numbers counted from the MSB.
  int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                    64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                    37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Textbook f on MSB-first numbers: bit p (1-based) of a w-bit value v is v[w-p].
  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    int six, row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    s = 0;
    for (int b = 0; b < 8; b++) begin
      six = int'((x >> (42 - 6*b)) & 48'h3f);
      row = ((six >> 5) & 1) * 2 + (six & 1);
      col = (six >> 1) & 15;
      s = (s << 4) | 32'(SB[b][row*16 + col]);
    end
    for (int i = 0; i < 32; i++) m_f[31-i] = s[32-P_T[i]];
  endfunction

  // Whole-cipher model: build all 16 subkeys, then walk them forwards or backwards.
  function automatic logic [63:0] m_des(input logic [63:0] key, input logic [63:0] din, input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] x, pre;
    logic [31:0] l, r, t;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SH[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 64; i++) x[63-i] = din[64-IP_T[i]];
    l = x[63:32];
    r = x[31:0];
    for (int n = 0; n < 16; n++) begin
      t = r;
      r = l ^ m_f(r, dec ? ks[15-n] : ks[n]);
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) m_des[63-i] = pre[64-FP_T[i]];
  endfunction

  task automatic send_exp(input logic m, input logic [63:0] k, input logic [63:0] d, input logic [63:0] e);
    bus.req_valid = 1'b1;
    bus.req_mode  = m;
    bus.req_key   = k;
    bus.req_data  = d;
    exp_q.push_back(e);
    exp_t.push_back(cyc + 1 + LAT);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [63:0] k, input logic [63:0] d);
    send_exp(m, k, d, m_des(k, d, m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid = 1'b0;
      bus.req_mode  = 1'($urandom_range(0, 1));
      bus.req_key   = {$urandom, $urandom};
      bus.req_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid got %b expected 0", name, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_data !== 64'h0) begin
      errors++;
      $display("FAIL %s_data got %h expected 0000000000000000", name, bus.rsp_data);
    end
  endtask

  // Monitor: every valid output pops one expected block and its expected arrival cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    int t;
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h at cycle %0d expected no output", bus.rsp_data, cyc);
      end else begin
        e = exp_q.pop_front();
        t = exp_t.pop_front();
        if (bus.rsp_data !== e) begin
          errors++;
          $display("FAIL data got %h expected %h at cycle %0d", bus.rsp_data, e, cyc);
        end
        checks++;
        if (cyc != t) begin
          errors++;
          $display("FAIL latency got cycle %0d expected cycle %0d", cyc, t);
        end
      end
    end
  end

  logic [63:0] vk [120];
  logic [63:0] vp [120];
  logic [63:0] vc [120];

  initial begin
    logic m;
    int p, n_vec, wait_cyc;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_mode  = 1'b0;
    bus.req_key   = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    reset = 1'b0;

    // Known answers, back to back.
    send_exp(1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    send_exp(1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
    send_exp(1'b0, 64'h0101010101010101, 64'h8000000000000000, 64'h95F8A5E5DD31D900);
    send_exp(1'b0, 64'h0000000000000000, 64'h8000000000000000, 64'h95F8A5E5DD31D900);
    send_exp(1'b0, 64'h8001010101010101, 64'h0000000000000000, 64'h95A8D72813DAA94D);
    idle(20);

    // Variable-plaintext and variable-key sets streamed, gap, then decrypted back.
    n_vec = 0;
    for (int i = 0; i < 64; i++) begin
      vk[n_vec] = 64'h0101010101010101;
      vp[n_vec] = 64'h8000000000000000 >> i;
      n_vec++;
    end
    for (int i = 0; i < 64; i++) begin
      p = i + 1;
      if (p % 8 != 0) begin
        vk[n_vec] = 64'h0101010101010101 | (64'h1 << (64 - p));
        vp[n_vec] = 64'h0;
        n_vec++;
      end
    end
    for (int i = 0; i < n_vec; i++) begin
      vc[i] = m_des(vk[i], vp[i], 1'b0);
      send_exp(1'b0, vk[i], vp[i], vc[i]);
    end
    idle(10);
    for (int i = 0; i < n_vec; i++) send_exp(1'b1, vk[i], vc[i], vp[i]);
    idle(5);

    // Random traffic: mode flips on every accepted block, random bubbles.
    m = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        send(m, {$urandom, $urandom}, {$urandom, $urandom});
        m = ~m;
      end
    end
    for (int i = 0; i < 30; i++) begin
      vk[i] = {$urandom, $urandom};
      vp[i] = {$urandom, $urandom};
      send_exp(1'b1, vk[i], m_des(vk[i], vp[i], 1'b0), vp[i]);
    end

    // One-cycle reset with the pipe full; valid_i is held high to show it is ignored.
    for (int i = 0; i < 10; i++) send(1'(i % 2), {$urandom, $urandom}, {$urandom, $urandom});
    reset = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid");
    exp_q.delete();
    exp_t.delete();
    reset = 1'b0;
    idle(3);
    for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 200) begin
      idle(1);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
    idle(LAT + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
